cbb_ecc_dec_pipe: RTL and testbench
===================================

// Module: cbb_ecc_dec_pipe
// PURPOSE
//  Parametrised, pipelined SECDED decoder with valid/ready flow control.
//  Corrects single-bit errors, flags double-bit errors and keeps saturating error counters.
//  Holds a first-error log for firmware.
//  Sits between ECC-protected storage (SRAM/FIFO read port) and the consumer.
//  Runtime bypass mode is provided for raw-array test.
// PARAMETERS
//  DW     32  data width, 1..247
//  EW     7   check width = Hamming bits + 1 overall parity; needs 2^(EW-1) >= DW+EW
//  PIPE   1   pipeline stages, 1 or 2; other values are illegal (elaboration error)
//  CNT_W  16  width of the SEC/DED counters
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          asynchronous active-low reset
//  ecc_en       in   1          1 = decode/correct; 0 = bypass
//  in_vld       in   1          input codeword valid
//  in_rdy       out  1          decoder can accept a codeword
//  din          in   DW+EW      {ecc[EW-1:0], data[DW-1:0]}
//  out_vld      out  1          output valid
//  out_rdy      in   1          consumer accepts output
//  dout         out  DW         corrected data
//  sec          out  1          single error corrected (qualified by out_vld)
//  ded          out  1          double error detected (qualified by out_vld)
//  syn          out  EW-1       raw syndrome of this beat
//  sec_cnt      out  CNT_W      saturating count of SEC beats
//  ded_cnt      out  CNT_W      saturating count of DED beats
//  clr_cnt      in   1          synchronous clear of both counters
//  log_vld      out  1          first-error log holds an entry
//  log_ded      out  1          logged error was DED (0 = SEC)
//  log_syn      out  EW-1       syndrome of the logged error
//  log_ovf      out  1          a further error occurred while log_vld=1
//  clr_log      in   1          synchronous clear of log_vld/log_ded/log_syn/log_ovf
// BEHAVIOUR
//  Code
//  - Hamming positions 1..DW+EW-1.
//  - Check bit j (j<EW-1) sits at position 2^j.
//  - Data bit i takes the i-th non-power-of-two position, ascending.
//  - ecc[j] = XOR of data bits whose position has bit j set.
//  - ecc[EW-1] = XOR of all data bits and ecc[EW-2:0] (even overall parity).
//  Decode
//  - syn = recomputed XOR received check bits; par = XOR of all DW+EW input bits.
//  - par=1 -> sec=1, ded=0. Flip data bit i iff syn == position(i);
//    otherwise a check bit is in error and data passes unchanged.
//  - par=0 and syn!=0 -> ded=1, sec=0, data passes uncorrected.
//  - par=0 and syn==0 -> clean beat.
//  - ecc_en=0 -> dout=data, sec=ded=0, syn=0; counters and log untouched.
//    ecc_en is sampled with the beat at input acceptance.
//  Pipeline
//  - Latency is PIPE cycles from accept (in_vld&in_rdy) to out_vld.
//  - PIPE=2: stage 1 registers data/syn/par; stage 2 registers the corrected result.
//  - A stage loads when it is empty or its downstream transfers this cycle.
//  - in_rdy = !stage1_vld | stage1_advances (combinational from out_rdy).
//  - Full throughput of 1 beat/cycle with out_rdy=1.
//  - No beat is lost or duplicated under any out_rdy pattern.
//  - While out_vld=1 and out_rdy=0: dout/sec/ded/syn hold stable.
//  Counters
//  - Increment on the output transfer (out_vld&out_rdy) with sec resp. ded set.
//  - Saturate at 2^CNT_W-1.
//  - clr_cnt wins over a same-cycle increment (result 0).
//  Log
//  - On an output transfer with sec|ded and log_vld=0: capture log_ded=ded,
//    log_syn=syn, and set log_vld.
//  - If log_vld=1 already: entry is kept and log_ovf=1.
//  - clr_log wins over a same-cycle capture (the error is dropped).
//  Reset
//  - All stage valids, out_vld, dout, sec, ded, syn, counters, log_* go to 0.
//  - in_rdy=1 once rst_n is deasserted.
//  - Reset mid-stream discards in-flight beats.
// TESTING
//  1. data=0x00000000, ecc=0x00 -> dout=0x00000000, sec=0, ded=0, out_vld exactly PIPE cycles after accept.
//  2. Flip data bit 0 (pos 3) -> syn=0x03, sec=1, dout=0x00000000, sec_cnt=1, log_vld=1, log_ded=0, log_syn=0x03.
//  3. Flip data bits 0 and 1 -> ded=1, sec=0, dout=0x00000003 (uncorrected), ded_cnt=1, log_ovf=1 (log already held).
//  4. Flip ecc[6] only -> sec=1, syn=0, dout unchanged; ecc_en=0 with 2 bits flipped -> raw data, no flags, counters hold.
//  5. 8 back-to-back beats, out_rdy held 0 for 5 cycles -> in_rdy drops once the pipe is full; all 8 beats out in order, unchanged.
//  6. CNT_W=2: 5 SEC beats -> sec_cnt=3; clr_cnt with a same-cycle SEC -> 0; rst_n low mid-stream -> out_vld=0 next edge.

Source files
------------

// File: rtl/cbb_ecc_dec_pipe.sv
// Pipelined SECDED decoder with valid/ready flow control, saturating error
// counters and a first-error log. ecc_en=0 passes raw data with no flags.
module cbb_ecc_dec_pipe #(
  parameter int DW    = 32,
  parameter int EW    = 7,
  parameter int PIPE  = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ecc_en,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [DW+EW-1:0]     din,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [DW-1:0]        dout,
  output logic                 sec,
  output logic                 ded,
  output logic [EW-2:0]        syn,
  output logic [CNT_W-1:0]     sec_cnt,
  output logic [CNT_W-1:0]     ded_cnt,
  input  logic                 clr_cnt,
  output logic                 log_vld,
  output logic                 log_ded,
  output logic [EW-2:0]        log_syn,
  output logic                 log_ovf,
  input  logic                 clr_log
);

  if (PIPE != 1 && PIPE != 2) begin : gBadPipe
    $error("cbb_ecc_dec_pipe: PIPE must be 1 or 2");
  end
  if ((1 << (EW - 1)) < DW + EW) begin : gBadEw
    $error("cbb_ecc_dec_pipe: EW too small for DW");
  end

  // Hamming position of data bit idx: the idx-th non-power-of-two position.
  function automatic logic [EW-2:0] dataPos(input int idx);
    int            cnt;
    logic [EW-2:0] res;
    cnt = 0;
    res = '0;
    for (int p = 3; p < (1 << (EW - 1)); p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p[EW-2:0];
        cnt++;
      end
    end
    return res;
  endfunction

  logic [DW-1:0] inData;
  logic [EW-2:0] inChk;
  logic [EW-2:0] inSyn;
  logic          inPar;

  assign inData = din[DW-1:0];
  assign inChk  = din[DW+EW-2:DW];
  assign inPar  = ^din;

  always_comb begin
    inSyn = inChk;
    for (int i = 0; i < DW; i++) begin
      if (inData[i]) inSyn = inSyn ^ dataPos(i);
    end
  end

  logic          outVld_q;
  logic          outAdv;
  logic          aVld;
  logic          aEn;
  logic          aPar;
  logic [DW-1:0] aData;
  logic [EW-2:0] aSyn;

  assign outAdv = !outVld_q || out_rdy;

  if (PIPE == 2) begin : gStage1
    logic          s1Vld_q;
    logic          s1En_q;
    logic          s1Par_q;
    logic [DW-1:0] s1Data_q;
    logic [EW-2:0] s1Syn_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1Vld_q  <= 1'b0;
        s1En_q   <= 1'b0;
        s1Par_q  <= 1'b0;
        s1Data_q <= '0;
        s1Syn_q  <= '0;
      end else if (in_rdy) begin
        s1Vld_q <= in_vld;
        if (in_vld) begin
          s1En_q   <= ecc_en;
          s1Par_q  <= inPar;
          s1Data_q <= inData;
          s1Syn_q  <= inSyn;
        end
      end
    end

    assign in_rdy = !s1Vld_q || outAdv;
    assign aVld   = s1Vld_q;
    assign aEn    = s1En_q;
    assign aPar   = s1Par_q;
    assign aData  = s1Data_q;
    assign aSyn   = s1Syn_q;
  end else begin : gNoStage1
    assign in_rdy = outAdv;
    assign aVld   = in_vld;
    assign aEn    = ecc_en;
    assign aPar   = inPar;
    assign aData  = inData;
    assign aSyn   = inSyn;
  end

  // Odd overall parity means one flipped bit; only data positions get repaired.
  logic [DW-1:0] fixData;
  logic          fixSec;
  logic          fixDed;
  logic [EW-2:0] fixSyn;

  always_comb begin
    fixData = aData;
    fixSec  = 1'b0;
    fixDed  = 1'b0;
    fixSyn  = '0;
    if (aEn) begin
      fixSyn = aSyn;
      if (aPar) begin
        fixSec = 1'b1;
        for (int i = 0; i < DW; i++) begin
          if (aSyn == dataPos(i)) fixData[i] = ~aData[i];
        end
      end else if (aSyn != '0) begin
        fixDed = 1'b1;
      end
    end
  end

  logic [DW-1:0] dout_q;
  logic          sec_q;
  logic          ded_q;
  logic [EW-2:0] syn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outVld_q <= 1'b0;
      dout_q   <= '0;
      sec_q    <= 1'b0;
      ded_q    <= 1'b0;
      syn_q    <= '0;
    end else if (outAdv) begin
      outVld_q <= aVld;
      if (aVld) begin
        dout_q <= fixData;
        sec_q  <= fixSec;
        ded_q  <= fixDed;
        syn_q  <= fixSyn;
      end
    end
  end

  logic             xfer;
  logic [CNT_W-1:0] secCnt_q, secCnt_d;
  logic [CNT_W-1:0] dedCnt_q, dedCnt_d;
  logic             logVld_q, logVld_d;
  logic             logDed_q, logDed_d;
  logic [EW-2:0]    logSyn_q, logSyn_d;
  logic             logOvf_q, logOvf_d;

  assign xfer = outVld_q && out_rdy;

  always_comb begin
    secCnt_d = secCnt_q;
    dedCnt_d = dedCnt_q;
    if (clr_cnt) begin
      secCnt_d = '0;
      dedCnt_d = '0;
    end else if (xfer) begin
      if (sec_q && secCnt_q != '1) secCnt_d = secCnt_q + 1'b1;
      if (ded_q && dedCnt_q != '1) dedCnt_d = dedCnt_q + 1'b1;
    end
  end

  always_comb begin
    logVld_d = logVld_q;
    logDed_d = logDed_q;
    logSyn_d = logSyn_q;
    logOvf_d = logOvf_q;
    if (clr_log) begin
      logVld_d = 1'b0;
      logDed_d = 1'b0;
      logSyn_d = '0;
      logOvf_d = 1'b0;
    end else if (xfer && (sec_q || ded_q)) begin
      if (!logVld_q) begin
        logVld_d = 1'b1;
        logDed_d = ded_q;
        logSyn_d = syn_q;
      end else begin
        logOvf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      secCnt_q <= '0;
      dedCnt_q <= '0;
      logVld_q <= 1'b0;
      logDed_q <= 1'b0;
      logSyn_q <= '0;
      logOvf_q <= 1'b0;
    end else begin
      secCnt_q <= secCnt_d;
      dedCnt_q <= dedCnt_d;
      logVld_q <= logVld_d;
      logDed_q <= logDed_d;
      logSyn_q <= logSyn_d;
      logOvf_q <= logOvf_d;
    end
  end

  assign out_vld = outVld_q;
  assign dout    = dout_q;
  assign sec     = sec_q;
  assign ded     = ded_q;
  assign syn     = syn_q;
  assign sec_cnt = secCnt_q;
  assign ded_cnt = dedCnt_q;
  assign log_vld = logVld_q;
  assign log_ded = logDed_q;
  assign log_syn = logSyn_q;
  assign log_ovf = logOvf_q;

endmodule

// File: tb/tb_cbb_ecc_dec_pipe.sv
// Scoreboard bench for cbb_ecc_dec_pipe: a position-based Hamming model predicts
// every beat, counter and log value; a negedge monitor compares against the DUT.
module tb_cbb_ecc_dec_pipe;

  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int PIPE  = 2;
  localparam int CNT_W = 2;
  localparam int N     = DW + EW - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ecc_en;
  logic               in_vld;
  logic               in_rdy;
  logic [DW+EW-1:0]   din;
  logic               out_vld;
  logic               out_rdy;
  logic [DW-1:0]      dout;
  logic               sec;
  logic               ded;
  logic [EW-2:0]      syn;
  logic [CNT_W-1:0]   sec_cnt;
  logic [CNT_W-1:0]   ded_cnt;
  logic               clr_cnt;
  logic               log_vld;
  logic               log_ded;
  logic [EW-2:0]      log_syn;
  logic               log_ovf;
  logic               clr_log;

  cbb_ecc_dec_pipe #(.DW(DW), .EW(EW), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ecc_en(ecc_en), .in_vld(in_vld), .in_rdy(in_rdy),
    .din(din), .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout), .sec(sec),
    .ded(ded), .syn(syn), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .clr_cnt(clr_cnt),
    .log_vld(log_vld), .log_ded(log_ded), .log_syn(log_syn), .log_ovf(log_ovf),
    .clr_log(clr_log)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          sec;
    logic          ded;
    logic [EW-2:0] syn;
  } exp_t;

  exp_t          sbQ[$];
  int            posOfData[DW];
  int            checks = 0;
  int            errors = 0;
  int            rdyMode = 0;
  int            expSec = 0;
  int            expDed = 0;
  bit            expLogVld = 0;
  bit            expLogDed = 0;
  bit            expLogOvf = 0;
  logic [EW-2:0] expLogSyn = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isPow2(input int p);
    bit r = 0;
    for (int j = 0; j < 16; j++) if (p == (1 << j)) r = 1;
    return r;
  endfunction

  function automatic logic [EW-1:0] refEncode(input logic [DW-1:0] d);
    bit [N:0]       cw = '0;
    logic [EW-1:0]  e = '0;
    for (int i = 0; i < DW; i++) cw[posOfData[i]] = d[i];
    for (int p = 1; p <= N; p++)
      for (int j = 0; j < EW - 1; j++)
        if (cw[p] && ((p >> j) & 1) == 1) e[j] = ~e[j];
    e[EW-1] = (^d) ^ (^e[EW-2:0]);
    return e;
  endfunction

  function automatic logic [DW+EW-1:0] cleanWord(input logic [DW-1:0] d);
    return {refEncode(d), d};
  endfunction

  // Syndrome = XOR of the positions of all set codeword bits.
  function automatic exp_t refDecode(input logic [DW+EW-1:0] w, input logic en);
    exp_t     e;
    bit [N:0] cw = '0;
    int       s = 0;
    for (int j = 0; j < EW - 1; j++) cw[1 << j] = w[DW + j];
    for (int i = 0; i < DW; i++) cw[posOfData[i]] = w[i];
    for (int p = 1; p <= N; p++) if (cw[p]) s = s ^ p;
    e.dout = w[DW-1:0];
    e.sec  = 1'b0;
    e.ded  = 1'b0;
    e.syn  = '0;
    if (en) begin
      e.syn = s[EW-2:0];
      if (^w) begin
        e.sec = 1'b1;
        for (int i = 0; i < DW; i++) if (posOfData[i] == s) e.dout[i] = ~e.dout[i];
      end else if (s != 0) begin
        e.ded = 1'b1;
      end
    end
    return e;
  endfunction

  // Monitor: compares output head every valid cycle, then advances the model.
  always @(negedge clk) begin
    exp_t head;
    bit   doXfer;
    head   = '0;
    doXfer = 0;
    if (!rst_n) begin
      sbQ.delete();
      expSec = 0; expDed = 0;
      expLogVld = 0; expLogDed = 0; expLogOvf = 0; expLogSyn = '0;
    end else begin
      checkOutput("sec_cnt", sec_cnt, expSec);
      checkOutput("ded_cnt", ded_cnt, expDed);
      checkOutput("log_vld", log_vld, expLogVld);
      checkOutput("log_ded", log_ded, expLogDed);
      checkOutput("log_syn", log_syn, expLogSyn);
      checkOutput("log_ovf", log_ovf, expLogOvf);
      if (out_vld) begin
        if (sbQ.size() == 0) begin
          checkOutput("spurious_out_vld", out_vld, 0);
        end else begin
          head = sbQ[0];
          checkOutput("dout", dout, head.dout);
          checkOutput("sec", sec, head.sec);
          checkOutput("ded", ded, head.ded);
          checkOutput("syn", syn, head.syn);
          if (out_rdy) begin
            void'(sbQ.pop_front());
            doXfer = 1;
          end
        end
      end
      if (clr_cnt) begin
        expSec = 0; expDed = 0;
      end else if (doXfer) begin
        if (head.sec && expSec < CMAX) expSec++;
        if (head.ded && expDed < CMAX) expDed++;
      end
      if (clr_log) begin
        expLogVld = 0; expLogDed = 0; expLogOvf = 0; expLogSyn = '0;
      end else if (doXfer && (head.sec || head.ded)) begin
        if (!expLogVld) begin
          expLogVld = 1; expLogDed = head.ded; expLogSyn = head.syn;
        end else begin
          expLogOvf = 1;
        end
      end
      if (in_vld && in_rdy) sbQ.push_back(refDecode(din, ecc_en));
    end
  end

  // Consumer/control driver; mode 3 leaves out_rdy and clears to the main thread.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdyMode)
      0: begin out_rdy = 1'b1; clr_cnt = 1'b0; clr_log = 1'b0; end
      1: begin
        out_rdy = ($urandom_range(0, 3) != 0);
        clr_cnt = ($urandom_range(0, 63) == 0);
        clr_log = ($urandom_range(0, 31) == 0);
      end
      2: begin out_rdy = 1'b0; clr_cnt = 1'b0; clr_log = 1'b0; end
      default: ;
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [DW+EW-1:0] word, input logic en);
    bit acc = 0;
    in_vld = 1'b1;
    din    = word;
    ecc_en = en;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
    in_vld = 1'b0;
  endtask

  task automatic waitDrain();
    bit done = 0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && !out_vld) done = 1;
    end
    if (!done) checkOutput("drain_timeout", sbQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW+EW-1:0] w;
    bit               seenVld;
    int               b1, b2;
    begin
      int k = 0;
      for (int p = 1; p <= N; p++) if (!isPow2(p)) begin posOfData[k] = p; k++; end
    end
    rst_n = 1'b0; ecc_en = 1'b1; in_vld = 1'b0; din = '0;
    out_rdy = 1'b1; clr_cnt = 1'b0; clr_log = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_sec_cnt", sec_cnt, 0);
    checkOutput("rst_log_vld", log_vld, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;

    // Clean zero word: latency is exactly PIPE cycles.
    in_vld = 1'b1; din = '0; ecc_en = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    for (int c = 1; c <= PIPE; c++) begin
      @(negedge clk);
      checkOutput((c == PIPE) ? "latency_vld" : "latency_early", out_vld, (c == PIPE));
    end
    checkOutput("zero_dout", dout, 0);
    @(posedge clk); #1;
    waitDrain();

    applyStimulus({7'h00, 32'h0000_0001}, 1'b1);
    waitDrain();
    checkOutput("t2_sec_cnt", sec_cnt, 1);
    checkOutput("t2_log_vld", log_vld, 1);
    checkOutput("t2_log_ded", log_ded, 0);
    checkOutput("t2_log_syn", log_syn, 3);

    applyStimulus({7'h00, 32'h0000_0003}, 1'b1);
    waitDrain();
    checkOutput("t3_ded_cnt", ded_cnt, 1);
    checkOutput("t3_log_ovf", log_ovf, 1);
    checkOutput("t3_log_syn", log_syn, 3);

    applyStimulus({7'h40, 32'h0000_0000}, 1'b1);
    waitDrain();
    checkOutput("t4_sec_cnt", sec_cnt, 2);
    applyStimulus({7'h00, 32'h0000_0003}, 1'b0);
    waitDrain();
    checkOutput("t4_byp_sec_cnt", sec_cnt, 2);
    checkOutput("t4_byp_ded_cnt", ded_cnt, 1);

    rdyMode = 3; clr_log = 1'b1;
    @(posedge clk); #1;
    clr_log = 1'b0; rdyMode = 0;
    @(negedge clk);
    checkOutput("clr_log_vld", log_vld, 0);
    checkOutput("clr_log_ovf", log_ovf, 0);
    @(posedge clk); #1;

    // Eight back-to-back beats against a stalled consumer.
    rdyMode = 2;
    fork
      for (int i = 0; i < 8; i++) applyStimulus(cleanWord($urandom), 1'b1);
      begin
        repeat (5) @(negedge clk);
        checkOutput("t5_in_rdy_full", in_rdy, 0);
        @(posedge clk); #1;
        rdyMode = 0;
      end
    join
    waitDrain();

    rdyMode = 1;
    for (int n = 0; n < 300; n++) begin
      w  = cleanWord($urandom);
      b1 = $urandom_range(0, 2);
      if (b1 > 0) begin
        b2 = $urandom_range(0, DW + EW - 1);
        w[b2] = ~w[b2];
        if (b1 == 2) begin
          b1 = b2;
          while (b1 == b2) b1 = $urandom_range(0, DW + EW - 1);
          w[b1] = ~w[b1];
        end
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      applyStimulus(w, ($urandom_range(0, 7) != 0));
    end
    rdyMode = 0;
    waitDrain();

    // Saturation and clear-versus-increment.
    rdyMode = 3; out_rdy = 1'b1; clr_cnt = 1'b1; clr_log = 1'b0;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus({7'h00, 32'h0000_0001}, 1'b1);
    waitDrain();
    checkOutput("sat_sec_cnt", sec_cnt, CMAX);
    out_rdy = 1'b0;
    applyStimulus({7'h00, 32'h0000_0001}, 1'b1);
    seenVld = 0;
    for (int t = 0; t < 20 && !seenVld; t++) begin
      @(negedge clk);
      seenVld = out_vld;
    end
    checkOutput("clr_wait_vld", seenVld, 1);
    @(posedge clk); #1;
    out_rdy = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    checkOutput("clr_wins_sec_cnt", sec_cnt, 0);
    @(posedge clk); #1;
    rdyMode = 0;
    waitDrain();

    // Reset with beats in flight.
    rdyMode = 2;
    applyStimulus({7'h00, 32'h0000_0001}, 1'b1);
    applyStimulus(cleanWord($urandom), 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_vld", out_vld, 0);
    checkOutput("midrst_sec_cnt", sec_cnt, 0);
    checkOutput("midrst_log_vld", log_vld, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rdyMode = 0;
    @(negedge clk);
    checkOutput("postrst_in_rdy", in_rdy, 1);
    @(negedge clk);
    checkOutput("postrst_out_vld", out_vld, 0);
    @(posedge clk); #1;
    applyStimulus(cleanWord(32'hA5A5_5A5A), 1'b1);
    waitDrain();

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
